// File: rtl/rbus_pkt_buffer_if.sv
// Handshake/bus bundle between rbus_muxNtoM_5x3 (producer), rbus_pkt_buffer and its consumer.
// slave = buffer view, master = surrounding environment view.
interface rbus_pkt_buffer_if;
  logic        i_stb;
  logic        i_sof;
  logic [71:0] i_data;
  logic [1:0]  i_rdy;
  logic [1:0]  i_rdyE;
  logic        o_stb;
  logic        o_sof;
  logic [71:0] o_data;
  logic [1:0]  o_rdy;
  logic [1:0]  o_rdyE;

  modport slave (
    input  i_stb, i_sof, i_data, o_rdy, o_rdyE,
    output i_rdy, i_rdyE, o_stb, o_sof, o_data
  );

  modport master (
    output i_stb, i_sof, i_data, o_rdy, o_rdyE,
    input  i_rdy, i_rdyE, o_stb, o_sof, o_data
  );
endinterface

// File: rtl/rbus_pkt_buffer.sv
// Packet-granular store-and-forward buffer with per-priority free-space readiness and sticky error.
// Optional cut-through mode: define RBUS_PKT_BUFFER_CUT_THROUGH_EN.
module rbus_pkt_buffer #(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned LONG_LEN   = 9
) (
  input  logic             clk,
  input  logic             rst,
  rbus_pkt_buffer_if.slave bus,
  output logic             ff_err
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned CW    = $clog2(LONG_LEN + 1);
  localparam int          LL    = int'(LONG_LEN);
  localparam int          DP    = int'(DEPTH);

  typedef enum logic {IN_IDLE, IN_PKT}   in_state_e;
  typedef enum logic {OUT_IDLE, OUT_PKT} out_state_e;

  in_state_e         r_in_state;
  out_state_e        r_out_state;
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_pkt_start;
  logic [PW-1:0]     r_dq_wr, r_dq_rd;
  logic [CW-1:0]     r_in_cnt, r_out_cnt;
  logic              r_in_prio;
  logic              r_o_stb, r_o_sof;
  logic [71:0]       r_o_data;
  logic [1:0]        r_i_rdy, r_i_rdyE;
  logic              r_err;
  logic [71:0]       r_mem  [DEPTH];
  logic [1:0]        r_desc [DEPTH];

  logic [PW-1:0]     w_used;
  logic              w_full;
  logic              w_hdr_prio, w_hdr_long;
  logic              w_wr_en, w_push, w_push_prio, w_push_long, w_abort, w_err_set;
  int                w_resv, w_free;
  logic [1:0]        w_desc;
  logic              w_dq_empty, w_start, w_avail, w_rd_word;
  logic              w_unused;

  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_used == PW'(DEPTH));
  assign w_hdr_prio = bus.i_data[71];
  assign w_hdr_long = bus.i_data[70];
  assign w_unused   = ^bus.o_rdyE;

  // Input side decode: what happens to the word presented this cycle.
  always_comb begin
    w_wr_en     = 1'b0;
    w_push      = 1'b0;
    w_push_prio = 1'b0;
    w_push_long = 1'b0;
    w_abort     = 1'b0;
    w_err_set   = 1'b0;
    case (r_in_state)
      IN_IDLE: begin
        if (bus.i_stb) begin
          if (!bus.i_sof || w_full) begin
            w_err_set = 1'b1;
          end else begin
            w_wr_en     = 1'b1;
            w_err_set   = ~r_i_rdy[w_hdr_prio];
            w_push_prio = w_hdr_prio;
            w_push_long = w_hdr_long;
`ifdef RBUS_PKT_BUFFER_CUT_THROUGH_EN
            w_push      = 1'b1;
`else
            w_push      = ~w_hdr_long;
`endif
          end
        end
      end
      IN_PKT: begin
        if (bus.i_stb) begin
          if (bus.i_sof) begin
            w_err_set = 1'b1;
            w_abort   = 1'b1;
          end else if (w_full) begin
            w_err_set = 1'b1;
          end else begin
            w_wr_en     = 1'b1;
            w_push_prio = r_in_prio;
            w_push_long = 1'b1;
`ifdef RBUS_PKT_BUFFER_CUT_THROUGH_EN
            w_push      = 1'b0;
`else
            w_push      = (r_in_cnt == CW'(LONG_LEN - 1));
`endif
          end
        end
      end
      default: ;
    endcase
  end

  // Free space excludes the unwritten tail of the packet in flight.
  always_comb begin
    w_resv = 0;
    if (r_in_state == IN_PKT) w_resv = LL - int'(r_in_cnt);
    w_free = DP - int'(w_used) - w_resv;
  end

  assign w_desc     = r_desc[r_dq_rd[DEPTH_LOG2-1:0]];
  assign w_dq_empty = (r_dq_wr == r_dq_rd);
  // Gating on r_o_stb leaves one idle cycle between consecutive packets.
  assign w_start    = (r_out_state == OUT_IDLE) && !w_dq_empty && bus.o_rdy[w_desc[1]] && !r_o_stb;
`ifdef RBUS_PKT_BUFFER_CUT_THROUGH_EN
  assign w_avail    = (r_rd_ptr != r_wr_ptr);
`else
  assign w_avail    = 1'b1;
`endif
  assign w_rd_word  = w_start || ((r_out_state == OUT_PKT) && w_avail);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= bus.i_data;
    if (w_push)  r_desc[r_dq_wr[DEPTH_LOG2-1:0]] <= {w_push_prio, w_push_long};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_state  <= IN_IDLE;
      r_out_state <= OUT_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pkt_start <= '0;
      r_dq_wr     <= '0;
      r_dq_rd     <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_in_prio   <= 1'b0;
      r_o_stb     <= 1'b0;
      r_o_sof     <= 1'b0;
      r_o_data    <= '0;
      r_i_rdy     <= '0;
      r_i_rdyE    <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_err_set) r_err <= 1'b1;
      r_i_rdy  <= {w_free >= LL, w_free >= 2 * LL};
      r_i_rdyE <= {w_free >= 2 * LL, w_free >= 3 * LL};

      if (w_abort) begin
`ifdef RBUS_PKT_BUFFER_CUT_THROUGH_EN
        // Header already published: later words complete the damaged packet.
`else
        r_wr_ptr <= r_pkt_start;
`endif
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_push) r_dq_wr <= r_dq_wr + 1'b1;

      case (r_in_state)
        IN_IDLE: begin
          if (w_wr_en) begin
            r_pkt_start <= r_wr_ptr;
            r_in_prio   <= w_hdr_prio;
            r_in_cnt    <= CW'(1);
            if (w_hdr_long) r_in_state <= IN_PKT;
          end
        end
        IN_PKT: begin
          if (w_abort) begin
            r_in_state <= IN_IDLE;
          end else if (w_wr_en) begin
            r_in_cnt <= r_in_cnt + 1'b1;
            if (r_in_cnt == CW'(LONG_LEN - 1)) r_in_state <= IN_IDLE;
          end
        end
        default: r_in_state <= IN_IDLE;
      endcase

      r_o_stb <= w_rd_word;
      r_o_sof <= w_start;
      if (w_rd_word) begin
        r_o_data <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case (r_out_state)
        OUT_IDLE: begin
          if (w_start) begin
            r_dq_rd <= r_dq_rd + 1'b1;
            if (w_desc[0]) begin
              r_out_state <= OUT_PKT;
              r_out_cnt   <= CW'(LONG_LEN - 1);
            end
          end
        end
        OUT_PKT: begin
          if (w_avail) begin
            r_out_cnt <= r_out_cnt - 1'b1;
            if (r_out_cnt == CW'(1)) r_out_state <= OUT_IDLE;
          end
        end
        default: r_out_state <= OUT_IDLE;
      endcase
    end
  end

  assign bus.i_rdy  = r_i_rdy;
  assign bus.i_rdyE = r_i_rdyE;
  assign bus.o_stb  = r_o_stb;
  assign bus.o_sof  = r_o_sof;
  assign bus.o_data = r_o_data;
  assign ff_err     = r_err;
endmodule

// File: tb/tb_rbus_pkt_buffer.sv
// Bench for rbus_pkt_buffer: packet table with latency/burst checks, scoreboard on every output
// word, and hand sequences for fill thresholds, head-of-line blocking, abort and reset.
module tb_rbus_pkt_buffer;
  logic clk = 1'b0;
  logic rst;
  logic ff_err;

  always #5 clk = ~clk;

  rbus_pkt_buffer_if bus ();

  rbus_pkt_buffer #(
    .DEPTH_LOG2(5),
    .LONG_LEN  (9)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .ff_err(ff_err)
  );

  typedef struct {
    logic [71:0] data;
    logic        sof;
  } exp_t;

  typedef struct {
    logic       prio;
    logic       lng;
    int         gap;
    logic [1:0] ordy;
    int         exp_lat;
    int         exp_run;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[6];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_in_cyc = 0;
  int run = 0;
  int last_run = 0;
  int n_out = 0;
  int cur_lat = 2;
  int n0;
  bit lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else if (bus.o_stb) begin
      n_out++;
      if (bus.o_sof) begin
        run = 1;
        if (lat_chk) chk("latency", 72'(cyc - last_in_cyc), 72'(cur_lat));
      end else begin
        run++;
      end
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %h, expected no output", bus.o_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.o_data, e.data);
        chk("out_sof", 72'(bus.o_sof), 72'(e.sof));
      end
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic drive_word(input logic sof, input logic [71:0] data);
    @(posedge clk);
    #1;
    bus.i_stb  = 1'b1;
    bus.i_sof  = sof;
    bus.i_data = data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.i_stb = 1'b0;
      bus.i_sof = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic prio, input logic lng, input int gap, input bit exp_out);
    int n;
    logic [71:0] w;
    n = lng ? 9 : 1;
    for (int i = 0; i < n; i++) begin
      if (i == 0) w = {prio, lng, 6'($urandom()), $urandom(), $urandom()};
      else        w = {8'($urandom()), $urandom(), $urandom()};
      drive_word(i == 0, w);
      if (exp_out) sb.push_back('{data: w, sof: (i == 0)});
      if (i == n - 1) last_in_cyc = cyc;
      else if (gap > 0) idle(gap);
    end
    idle(1);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && bus.o_stb == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    #1;
    chk(name, 72'(ok), 72'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_stb  = 1'b0;
    bus.i_sof  = 1'b0;
    bus.i_data = '0;
    bus.o_rdy  = 2'b11;
    bus.o_rdyE = 2'b00;
    rst        = 1'b1;

    tbl[0] = '{prio: 1'b1, lng: 1'b0, gap: 0, ordy: 2'b11, exp_lat: 2, exp_run: 1};
    tbl[1] = '{prio: 1'b0, lng: 1'b0, gap: 0, ordy: 2'b11, exp_lat: 2, exp_run: 1};
    tbl[2] = '{prio: 1'b1, lng: 1'b1, gap: 2, ordy: 2'b11, exp_lat: 2, exp_run: 9};
    tbl[3] = '{prio: 1'b0, lng: 1'b1, gap: 0, ordy: 2'b11, exp_lat: 2, exp_run: 9};
    tbl[4] = '{prio: 1'b0, lng: 1'b1, gap: 3, ordy: 2'b01, exp_lat: 2, exp_run: 9};
    tbl[5] = '{prio: 1'b1, lng: 1'b0, gap: 1, ordy: 2'b10, exp_lat: 2, exp_run: 1};

    // Reset state and first clock after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_rdy", 72'(bus.i_rdy), 72'(0));
    chk("rst_o_stb", 72'(bus.o_stb), 72'(0));
    chk("rst_ff_err", 72'(ff_err), 72'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("rdy_before_clk", 72'(bus.i_rdy), 72'(0));
    @(posedge clk);
    #2;
    chk("idle_i_rdy", 72'(bus.i_rdy), 72'(2'b11));
    chk("idle_i_rdyE", 72'(bus.i_rdyE), 72'(2'b11));
    chk("idle_o_stb", 72'(bus.o_stb), 72'(0));
    chk("idle_ff_err", 72'(ff_err), 72'(0));

    // Single packets into an empty buffer.
    lat_chk = 1'b1;
    for (int t = 0; t < 6; t++) begin
      bus.o_rdy = tbl[t].ordy;
      cur_lat   = tbl[t].exp_lat;
      last_run  = 0;
      send_pkt(tbl[t].prio, tbl[t].lng, tbl[t].gap, 1'b1);
      wait_drain("tbl_drain");
      chk("tbl_run_len", 72'(last_run), 72'(tbl[t].exp_run));
    end
    lat_chk = 1'b0;
    chk("tbl_ff_err", 72'(ff_err), 72'(0));

    // Fill with consumer stalled: prio-0 threshold falls before prio-1.
    bus.o_rdy = 2'b00;
    send_pkt(1'b0, 1'b1, 0, 1'b1);
    idle(1);
    chk("fill1_i_rdy", 72'(bus.i_rdy), 72'(2'b11));
    chk("fill1_i_rdyE", 72'(bus.i_rdyE), 72'(2'b10));
    send_pkt(1'b0, 1'b1, 1, 1'b1);
    idle(1);
    chk("fill2_i_rdy", 72'(bus.i_rdy), 72'(2'b10));
    chk("fill2_i_rdyE", 72'(bus.i_rdyE), 72'(2'b00));
    send_pkt(1'b1, 1'b1, 0, 1'b1);
    idle(1);
    chk("fill3_i_rdy", 72'(bus.i_rdy), 72'(2'b00));
    chk("fill3_ff_err", 72'(ff_err), 72'(0));
    bus.o_rdy = 2'b11;
    wait_drain("fill_drain");
    idle(1);
    chk("fill_empty_i_rdy", 72'(bus.i_rdy), 72'(2'b11));

    // Head-of-line blocking on a prio-0 packet.
    bus.o_rdy = 2'b10;
    send_pkt(1'b0, 1'b0, 0, 1'b1);
    send_pkt(1'b1, 1'b0, 0, 1'b1);
    n0 = n_out;
    idle(8);
    chk("hol_blocked", 72'(n_out - n0), 72'(0));
    bus.o_rdy = 2'b11;
    wait_drain("hol_drain");
    chk("hol_released", 72'(n_out - n0), 72'(2));

    // New header at word 4 of a long packet.
    drive_word(1'b1, {1'b1, 1'b1, 6'($urandom()), $urandom(), $urandom()});
    for (int i = 0; i < 3; i++) drive_word(1'b0, {8'($urandom()), $urandom(), $urandom()});
    drive_word(1'b1, {1'b0, 1'b0, 6'($urandom()), $urandom(), $urandom()});
    idle(2);
    chk("abort_ff_err", 72'(ff_err), 72'(1));
    send_pkt(1'b1, 1'b1, 0, 1'b1);
    send_pkt(1'b0, 1'b0, 0, 1'b1);
    wait_drain("abort_drain");

    // Reset in the middle of a packet discards it.
    drive_word(1'b1, {1'b0, 1'b1, 6'($urandom()), $urandom(), $urandom()});
    drive_word(1'b0, {8'($urandom()), $urandom(), $urandom()});
    drive_word(1'b0, {8'($urandom()), $urandom(), $urandom()});
    n0 = n_out;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.i_stb = 1'b0;
    bus.i_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    chk("rstmid_ff_err", 72'(ff_err), 72'(0));
    chk("rstmid_i_rdy", 72'(bus.i_rdy), 72'(2'b11));
    idle(4);
    chk("rstmid_no_out", 72'(n_out - n0), 72'(0));
    send_pkt(1'b1, 1'b0, 0, 1'b1);
    wait_drain("rstmid_drain");

    // Word without sof while idle is dropped and flagged.
    n0 = n_out;
    drive_word(1'b0, {8'($urandom()), $urandom(), $urandom()});
    idle(4);
    chk("stray_ff_err", 72'(ff_err), 72'(1));
    chk("stray_no_out", 72'(n_out - n0), 72'(0));
    chk("sb_empty", 72'(sb.size()), 72'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
